// File: rtl/route_collector.sv
// Collects the enabled lanes of a LANE_W-lane bus back into a packed DOUT_W-bit word, LANES_PER_CYC lanes per cycle.
// Optional parity on the packed word and its check are enabled by defining ROUTE_COLLECTOR_PARITY_EN.
module route_collector #(
    parameter int DOUT_W        = 70,
    parameter int LANE_W        = 128,
    parameter int LANES_PER_CYC = 8,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANE_W-1:0]   sw_i,
    input  logic [LANE_W-1:0]   lane_i,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DOUT_W-1:0]   dout,
    output logic [CNT_W-1:0]    lane_cnt,
    output logic                ovf,
    output logic                out_valid,
    input  logic                out_ready
`ifdef ROUTE_COLLECTOR_PARITY_EN
    ,
    input  logic                din_par,
    output logic                dout_par,
    output logic                par_err
`endif
);

    localparam int N_CHUNKS = LANE_W / LANES_PER_CYC;
    localparam int CHUNK_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK_C = CHUNK_W'(N_CHUNKS - 1);
    localparam logic [CNT_W-1:0]   DOUT_LIM_C   = CNT_W'(DOUT_W);
    localparam logic [DOUT_W-1:0]  ONE_C        = {{(DOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [LANE_W-1:0]    sw_r;
    logic [LANE_W-1:0]    lane_r;
    logic [DOUT_W-1:0]    acc_r;
    logic [CNT_W-1:0]     ptr_r;
    logic [CHUNK_W-1:0]   chunk_r;
    logic [DOUT_W-1:0]    acc_next_s;
    logic [CNT_W-1:0]     ptr_next_s;
    logic                 accept_s;
    logic                 last_chunk_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [DOUT_W-1:0]    dout_r;
    logic [CNT_W-1:0]     lane_cnt_r;
    logic                 ovf_r;
`ifdef ROUTE_COLLECTOR_PARITY_EN
    logic                 din_par_r;
    logic                 dout_par_r;
    logic                 par_err_r;
`endif

    // Even parity over a packed word.
    function automatic logic word_parity(input logic [DOUT_W-1:0] word);
        return ^word;
    endfunction

    assign accept_s     = in_valid && in_ready_r;
    assign last_chunk_s = (chunk_r == LAST_CHUNK_C);

    // Pack the low chunk of the shifting mask/data registers into the accumulator.
    // Lanes past DOUT_W shift the write bit out of the word, so they only bump the count.
    always_comb begin
        acc_next_s = acc_r;
        ptr_next_s = ptr_r;
        for (int j = 0; j < LANES_PER_CYC; j++) begin
            acc_next_s = acc_next_s | ({DOUT_W{sw_r[j] & lane_r[j]}} & (ONE_C << ptr_next_s));
            ptr_next_s = ptr_next_s + CNT_W'(sw_r[j]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = PACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PACK: begin
                if (last_chunk_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = PACK;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: capture, chunked packing and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_r        <= {LANE_W{1'b0}};
            lane_r      <= {LANE_W{1'b0}};
            acc_r       <= {DOUT_W{1'b0}};
            ptr_r       <= {CNT_W{1'b0}};
            chunk_r     <= {CHUNK_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dout_r      <= {DOUT_W{1'b0}};
            lane_cnt_r  <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
`ifdef ROUTE_COLLECTOR_PARITY_EN
            din_par_r   <= 1'b0;
            dout_par_r  <= 1'b0;
            par_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sw_r       <= sw_i;
                        lane_r     <= lane_i;
                        acc_r      <= {DOUT_W{1'b0}};
                        ptr_r      <= {CNT_W{1'b0}};
                        chunk_r    <= {CHUNK_W{1'b0}};
                        in_ready_r <= 1'b0;
`ifdef ROUTE_COLLECTOR_PARITY_EN
                        din_par_r  <= din_par;
`endif
                    end
                end
                PACK: begin
                    acc_r   <= acc_next_s;
                    ptr_r   <= ptr_next_s;
                    sw_r    <= sw_r >> LANES_PER_CYC;
                    lane_r  <= lane_r >> LANES_PER_CYC;
                    chunk_r <= chunk_r + CHUNK_W'(1);
                    if (last_chunk_s) begin
                        out_valid_r <= 1'b1;
                        dout_r      <= acc_next_s;
                        lane_cnt_r  <= ptr_next_s;
                        ovf_r       <= (ptr_next_s > DOUT_LIM_C);
`ifdef ROUTE_COLLECTOR_PARITY_EN
                        dout_par_r  <= word_parity(acc_next_s);
                        par_err_r   <= (din_par_r != word_parity(acc_next_s));
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
`ifdef ROUTE_COLLECTOR_PARITY_EN
                        par_err_r   <= 1'b0;
`endif
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign lane_cnt  = lane_cnt_r;
    assign ovf       = ovf_r;
`ifdef ROUTE_COLLECTOR_PARITY_EN
    assign dout_par  = dout_par_r;
    assign par_err   = par_err_r;
`endif

endmodule

// File: tb/tb_route_collector.sv
// Directed-vector and round-trip bench for route_collector.
// Parity ports are connected and checked when ROUTE_COLLECTOR_PARITY_EN is defined.
module tb_route_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] sw_i;
    logic [127:0] lane_i;
    logic         in_valid;
    logic         in_ready;
    logic [69:0]  dout;
    logic [7:0]   lane_cnt;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;
`ifdef ROUTE_COLLECTOR_PARITY_EN
    logic         din_par;
    logic         dout_par;
    logic         par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] sw;
        logic [127:0] ln;
        logic [69:0]  d;
        logic [7:0]   c;
        logic         o;
        logic         early;
    } vec_t;

    vec_t vecs[7];

    route_collector dut (
        .clk       (clk),
        .rst       (rst),
        .sw_i      (sw_i),
        .lane_i    (lane_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .lane_cnt  (lane_cnt),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROUTE_COLLECTOR_PARITY_EN
        ,
        .din_par   (din_par),
        .dout_par  (dout_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_txn(input logic [127:0] sw, input logic [127:0] ln);
        @(negedge clk);
        sw_i     = sw;
        lane_i   = ln;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sw_i     = 128'd0;
        lane_i   = 128'd0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", lat);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {127'd0, out_valid}, 128'd0);
        chk("in_ready_back", {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        int           lat;
        logic [69:0]  din;
        logic [69:0]  exp_d;
        logic [127:0] mask;
        logic [127:0] ln;
        int           n;
        int           cnt;
        int           k;
        int           idx;

        vecs[0] = '{128'h3F_FFFF_FFFF_FFFF_FFFF, 128'h2A_5555_AAAA_1234_5678,
                    70'h2A_5555_AAAA_1234_5678, 8'd70, 1'b0, 1'b0};
        vecs[1] = '{128'h8000_0000_0000_0001_0000_0000_0000_0010, 128'hFFFF_FFFF_FFFF_FFFE_FFFF_FFFF_FFFF_FFFF,
                    70'h5, 8'd3, 1'b0, 1'b0};
        vecs[2] = '{{128{1'b1}}, {128{1'b1}}, 70'h3F_FFFF_FFFF_FFFF_FFFF, 8'd128, 1'b1, 1'b0};
        vecs[3] = '{128'd0, {128{1'b1}}, 70'h0, 8'd0, 1'b0, 1'b0};
        vecs[4] = '{128'h7F_FFFF_FFFF_FFFF_FFFF, 128'h60_0000_0000_0000_0001,
                    70'h20_0000_0000_0000_0001, 8'd71, 1'b1, 1'b0};
        vecs[5] = '{128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
                    70'h00_FF00_FF00_FF00_FF00, 8'd64, 1'b0, 1'b0};
        vecs[6] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, {128{1'b1}}, 70'h1, 8'd1, 1'b0, 1'b1};

        rst       = 1'b0;
        sw_i      = 128'd0;
        lane_i    = 128'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ROUTE_COLLECTOR_PARITY_EN
        din_par   = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_dout", {58'd0, dout}, 128'd0);
        chk("rst_lane_cnt", {120'd0, lane_cnt}, 128'd0);
        chk("rst_ovf", {127'd0, ovf}, 128'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
`ifdef ROUTE_COLLECTOR_PARITY_EN
            din_par = ^vecs[i].d;
`endif
            out_ready = vecs[i].early;
            start_txn(vecs[i].sw, vecs[i].ln);
            chk("busy_in_ready", {127'd0, in_ready}, 128'd0);
            wait_valid(lat);
            chk($sformatf("latency_%0d", i), 128'(lat), 128'd16);
            chk($sformatf("dout_%0d", i), {58'd0, dout}, {58'd0, vecs[i].d});
            chk($sformatf("lane_cnt_%0d", i), {120'd0, lane_cnt}, {120'd0, vecs[i].c});
            chk($sformatf("ovf_%0d", i), {127'd0, ovf}, {127'd0, vecs[i].o});
`ifdef ROUTE_COLLECTOR_PARITY_EN
            chk($sformatf("dout_par_%0d", i), {127'd0, dout_par}, {127'd0, ^vecs[i].d});
            chk($sformatf("par_err_%0d", i), {127'd0, par_err}, 128'd0);
`endif
            accept();
        end

        // Backpressure with ignored in_valid pulses in DONE
        start_txn(vecs[0].sw, vecs[0].ln);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw_i     = {128{1'b1}};
            lane_i   = 128'd0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_dout", {58'd0, dout}, {58'd0, vecs[0].d});
            chk("bp_lane_cnt", {120'd0, lane_cnt}, 128'd70);
            chk("bp_ovf", {127'd0, ovf}, 128'd0);
        end
        accept();

        // Sparse vector right after backpressure, then reset in chunk 7
        start_txn(vecs[1].sw, vecs[1].ln);
        wait_valid(lat);
        chk("post_bp_dout", {58'd0, dout}, {58'd0, vecs[1].d});
        accept();
        start_txn(vecs[2].sw, vecs[2].ln);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("midrst_dout", {58'd0, dout}, 128'd0);
        chk("midrst_lane_cnt", {120'd0, lane_cnt}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        start_txn(vecs[0].sw, vecs[0].ln);
        wait_valid(lat);
        chk("after_rst_latency", 128'(lat), 128'd16);
        chk("after_rst_dout", {58'd0, dout}, {58'd0, vecs[0].d});
        chk("after_rst_lane_cnt", {120'd0, lane_cnt}, 128'd70);
        accept();

        // Round trip through a distributor model
        for (int it = 0; it < 1000; it++) begin
            din  = {6'($urandom), $urandom, $urandom};
            n    = $urandom_range(0, 70);
            mask = 128'd0;
            cnt  = 0;
            while (cnt < n) begin
                idx = $urandom_range(0, 127);
                if (!mask[idx]) begin
                    mask[idx] = 1'b1;
                    cnt++;
                end
            end
            k  = 0;
            ln = 128'd0;
            for (int i = 0; i < 128; i++) begin
                if (mask[i]) begin
                    ln[i] = din[k];
                    k++;
                end
            end
            exp_d = din & ((70'd1 << n) - 70'd1);
`ifdef ROUTE_COLLECTOR_PARITY_EN
            din_par = ^exp_d;
`endif
            start_txn(mask, ln);
            wait_valid(lat);
            chk("rt_dout", {58'd0, dout}, {58'd0, exp_d});
            chk("rt_lane_cnt", {120'd0, lane_cnt}, 128'(n));
            chk("rt_ovf", {127'd0, ovf}, 128'd0);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
